// File: rtl/loader_pkg.sv
// Shared constants and state types for the UART program loader.
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE            = 8'hA5;
   localparam int         DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_COUNT = 3'd1,
      LD_HI    = 3'd2,
      LD_LO    = 3'd3,
      LD_CHECK = 3'd4
   } load_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop input synchronizer plus a start/data/stop bit FSM.
// Emits a one-cycle byteValid with the byte, or a one-cycle frameErr when the
// stop bit is low. A start bit that is high again at mid-bit is a glitch.
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

   logic      rxMeta_q, rxSync_q, rxPrev_q;
   rx_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bitIdx_q, bitIdx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;

   // Bring rx into the clock domain; the previous synchronized value feeds edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   // Bit-timing FSM: find a falling edge, confirm at mid start bit, then sample mid-bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (rxPrev_q && !rxSync_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_BIT) begin
               cnt_d    = '0;
               bitIdx_d = '0;
               state_d  = rxSync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_BIT) begin
               cnt_d   = '0;
               shift_d = {rxSync_q, shift_q[7:1]};
               if (bitIdx_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_BIT) begin
               state_d = RX_IDLE;
               cnt_d   = '0;
               if (rxSync_q) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Receiver state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= RX_IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
      end
   end

   assign byte_valid_o = valid_q;
   assign byte_data_o  = data_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image from a UART stream into program RAM.
// Frame: SYNC, word count N, N x {hi, lo}, XOR checksum of all hi/lo bytes.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
   parameter int ADDR_WIDTH        = 8,
   parameter int INSTRUCTION_WIDTH = 4,
   parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
   parameter int TIMEOUT_CLKS      = 16 * 10 * CLKS_PER_BIT
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  rx_i,
   output logic                  program_write_o,
   output logic [ADDR_WIDTH-1:0] program_address_o,
   output logic [DATA_WIDTH-1:0] program_cmd_o,
   output logic                  busy_o,
   output logic                  load_done_o,
   output logic                  load_error_o
);

   localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   logic       byteValid;
   logic [7:0] byteData;
   logic       frameErr;

   load_state_t                  state_q, state_d;
   logic                         busy_q, busy_d;
   logic                         err_q, err_d;
   logic                         done_q, done_d;
   logic                         wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]        addrOut_q, addrOut_d;
   logic [DATA_WIDTH-1:0]        cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0]        wordAddr_q, wordAddr_d;
   logic [7:0]                   count_q, count_d;
   logic [7:0]                   written_q, written_d;
   logic [INSTRUCTION_WIDTH-1:0] hiOp_q, hiOp_d;
   logic [7:0]                   csum_q, csum_d;
   logic [TW-1:0]                tmo_q, tmo_d;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uRx (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .rx_i        (rx_i),
      .byte_valid_o(byteValid),
      .byte_data_o (byteData),
      .frame_err_o (frameErr)
   );

   // Session FSM: parses the frame, issues RAM writes, tracks checksum and idle timeout.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      err_d      = err_q;
      done_d     = 1'b0;
      wr_d       = 1'b0;
      addrOut_d  = addrOut_q;
      cmd_d      = cmd_q;
      wordAddr_d = wordAddr_q;
      count_d    = count_q;
      written_d  = written_q;
      hiOp_d     = hiOp_q;
      csum_d     = csum_q;
      tmo_d      = busy_q ? tmo_q + 1'b1 : '0;
      if (byteValid) begin
         tmo_d = '0;
         case (state_q)
            LD_IDLE: begin
               if (byteData == SYNC_BYTE) begin
                  busy_d     = 1'b1;
                  err_d      = 1'b0;
                  wordAddr_d = '0;
                  written_d  = '0;
                  csum_d     = '0;
                  state_d    = LD_COUNT;
               end
            end
            LD_COUNT: begin
               if (byteData == 8'd0) begin
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = LD_IDLE;
               end else begin
                  count_d = byteData;
                  state_d = LD_HI;
               end
            end
            LD_HI: begin
               hiOp_d  = byteData[INSTRUCTION_WIDTH-1:0];
               csum_d  = csum_q ^ byteData;
               state_d = LD_LO;
            end
            LD_LO: begin
               csum_d     = csum_q ^ byteData;
               wr_d       = 1'b1;
               addrOut_d  = wordAddr_q;
               cmd_d      = DATA_WIDTH'({hiOp_q, ADDR_WIDTH'(byteData)});
               wordAddr_d = wordAddr_q + 1'b1;
               written_d  = written_q + 8'd1;
               state_d    = (written_q + 8'd1 == count_q) ? LD_CHECK : LD_HI;
            end
            LD_CHECK: begin
               err_d   = err_q | (byteData != csum_q);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
         endcase
      end
      if (busy_q && (frameErr || (!byteValid && tmo_q == TMO_LAST))) begin
         state_d = LD_IDLE;
         busy_d  = 1'b0;
         err_d   = 1'b1;
         tmo_d   = '0;
      end
   end

   // Loader registers; reset abandons any session but RAM contents are untouched.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= LD_IDLE;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         wr_q       <= 1'b0;
         addrOut_q  <= '0;
         cmd_q      <= '0;
         wordAddr_q <= '0;
         count_q    <= '0;
         written_q  <= '0;
         hiOp_q     <= '0;
         csum_q     <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         done_q     <= done_d;
         wr_q       <= wr_d;
         addrOut_q  <= addrOut_d;
         cmd_q      <= cmd_d;
         wordAddr_q <= wordAddr_d;
         count_q    <= count_d;
         written_q  <= written_d;
         hiOp_q     <= hiOp_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
      end
   end

   assign program_write_o   = wr_q;
   assign program_address_o = addrOut_q;
   assign program_cmd_o     = cmd_q;
   assign busy_o            = busy_q;
   assign load_done_o       = done_q;
   assign load_error_o      = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: UART frames are driven serially, expected RAM
// writes and completion events are queued when a frame is built, and a monitor
// compares them against what the loader presents.
module tb_uart_program_loader;

   localparam int CPB = 8;
   localparam int AW  = 8;
   localparam int IW  = 4;
   localparam int DW  = AW + IW;
   localparam int TMO = 16 * 10 * CPB;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          rx = 1'b1;
   logic          progWrite;
   logic [AW-1:0] progAddr;
   logic [DW-1:0] progCmd;
   logic          busy;
   logic          loadDone;
   logic          loadError;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] cmd;
   } wr_t;

   wr_t        wrQ[$];
   logic       doneQ[$];
   logic [7:0] txQ[$];
   wr_t        expWr;
   logic       expErr;
   int         checks = 0;
   int         errors = 0;
   bit         monOn = 1'b0;

   uart_program_loader #(
      .CLKS_PER_BIT     (CPB),
      .ADDR_WIDTH       (AW),
      .INSTRUCTION_WIDTH(IW)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rstN),
      .rx_i             (rx),
      .program_write_o  (progWrite),
      .program_address_o(progAddr),
      .program_cmd_o    (progCmd),
      .busy_o           (busy),
      .load_done_o      (loadDone),
      .load_error_o     (loadError)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Hang guard: a stuck run still reports before stopping.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write or done pulse the DUT presents is matched against the queues.
   always @(negedge clk) begin
      if (monOn) begin
         if (progWrite) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpectedWrite", 1, 0);
            end else begin
               expWr = wrQ.pop_front();
               checkOutput("writeAddr", int'(progAddr), int'(expWr.addr));
               checkOutput("writeCmd", int'(progCmd), int'(expWr.cmd));
            end
         end
         if (loadDone) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpectedDone", 1, 0);
            end else begin
               expErr = doneQ.pop_front();
               checkOutput("doneError", int'(loadError), int'(expErr));
               checkOutput("busyAtDone", int'(busy), 0);
            end
         end
      end
   end

   // One UART frame: start, 8 data bits LSB first, chosen stop bit, short idle gap.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
      @(negedge clk) rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rx = b[i];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx = stopBit;
      repeat (CPB - 1) @(negedge clk);
      @(negedge clk) rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic sendAll();
      while (txQ.size() > 0) applyStimulus(txQ.pop_front(), 1'b1);
   endtask

   task automatic pushWrite(input int addr, input int cmd);
      wr_t w;
      w.addr = AW'(addr);
      w.cmd  = DW'(cmd);
      wrQ.push_back(w);
   endtask

   // End-of-session checks: idle, expected error flag, all expectations consumed.
   task automatic settle(input logic expErrFlag);
      int guard = 0;
      while (busy && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      repeat (4) @(negedge clk);
      checkOutput("busyIdle", int'(busy), 0);
      checkOutput("loadError", int'(loadError), int'(expErrFlag));
      checkOutput("writesDrained", wrQ.size(), 0);
      checkOutput("donesDrained", doneQ.size(), 0);
   endtask

   // Random session: optional junk byte, n random words, good or corrupted checksum.
   task automatic randomSession(input int n, input bit good, input bit junk);
      logic [7:0] hi, lo, c, jb;
      c = 8'h00;
      txQ.delete();
      if (junk) begin
         jb = 8'($urandom);
         if (jb == 8'hA5) jb = 8'h3C;
         txQ.push_back(jb);
      end
      txQ.push_back(8'hA5);
      txQ.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         hi = 8'($urandom);
         lo = 8'($urandom);
         txQ.push_back(hi);
         txQ.push_back(lo);
         c = c ^ hi ^ lo;
         pushWrite(i % (1 << AW), (int'(hi[IW-1:0]) << AW) | int'(lo));
      end
      if (!good) c = c ^ (8'h01 << $urandom_range(7, 0));
      txQ.push_back(c);
      doneQ.push_back(!good);
      sendAll();
      settle(!good);
   endtask

   // Directed scenarios followed by randomized sessions.
   initial begin
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetError", int'(loadError), 0);
      checkOutput("resetWrite", int'(progWrite), 0);
      checkOutput("resetDone", int'(loadDone), 0);
      rstN = 1'b1;
      monOn = 1'b1;
      repeat (5) @(negedge clk);

      // Basic two-word load, with a junk byte first.
      $display("[TB] basic load");
      pushWrite(0, 'h123);
      pushWrite(1, 'h0FF);
      doneQ.push_back(1'b0);
      applyStimulus(8'h3C, 1'b1);
      checkOutput("junkIgnored", int'(busy), 0);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("busyAfterSync", int'(busy), 1);
      txQ = '{8'h02, 8'h01, 8'h23, 8'h00, 8'hFF, 8'hDD};
      sendAll();
      settle(1'b0);

      // Bad checksum: writes still happen, error stays until next SYNC.
      $display("[TB] bad checksum");
      pushWrite(0, 'h123);
      pushWrite(1, 'h0FF);
      doneQ.push_back(1'b1);
      txQ = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'hFF, 8'h00};
      sendAll();
      settle(1'b1);
      repeat (200) @(negedge clk);
      checkOutput("errorSticky", int'(loadError), 1);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("errorClearedBySync", int'(loadError), 0);
      checkOutput("busyNewSession", int'(busy), 1);
      pushWrite(0, 'h566);
      doneQ.push_back(1'b0);
      txQ = '{8'h01, 8'h55, 8'h66, 8'h33};
      sendAll();
      settle(1'b0);

      // Glitch on the idle line, then a load whose HI byte has upper bits set.
      $display("[TB] glitch rejection");
      @(negedge clk) rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      checkOutput("glitchNoSession", int'(busy), 0);
      pushWrite(0, 'h140);
      doneQ.push_back(1'b0);
      txQ = '{8'hA5, 8'h01, 8'hF1, 8'h40, 8'hB1};
      sendAll();
      settle(1'b0);

      // Framing error mid-session aborts with error and no done.
      $display("[TB] framing error");
      pushWrite(0, 'h011);
      txQ = '{8'hA5, 8'h02, 8'h00, 8'h11};
      sendAll();
      checkOutput("busyBeforeFrameErr", int'(busy), 1);
      applyStimulus(8'h22, 1'b0);
      settle(1'b1);

      // Inter-byte timeout, then a clean session restarting at address 0.
      $display("[TB] timeout");
      pushWrite(0, 'h011);
      txQ = '{8'hA5, 8'h03, 8'h00, 8'h11};
      sendAll();
      repeat (TMO - 300) @(negedge clk);
      checkOutput("busyBeforeTimeout", int'(busy), 1);
      repeat (600) @(negedge clk);
      checkOutput("busyAfterTimeout", int'(busy), 0);
      settle(1'b1);
      randomSession(3, 1'b1, 1'b0);

      // Reset between HI and LO of the second word.
      $display("[TB] reset mid-session");
      pushWrite(0, 'h011);
      txQ = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22};
      sendAll();
      checkOutput("busyBeforeReset", int'(busy), 1);
      @(negedge clk) rstN = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstError", int'(loadError), 0);
      checkOutput("rstWrite", int'(progWrite), 0);
      checkOutput("rstDone", int'(loadDone), 0);
      checkOutput("rstAddr", int'(progAddr), 0);
      checkOutput("rstCmd", int'(progCmd), 0);
      rstN = 1'b1;
      repeat (5) @(negedge clk);
      txQ = '{8'hA5, 8'h00};
      sendAll();
      settle(1'b1);

      // Randomized sessions.
      $display("[TB] random sessions");
      for (int s = 0; s < 6; s++) begin
         randomSession(int'($urandom_range(4, 1)), $urandom_range(3, 0) != 0, 1'b1);
      end

      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
